// File: rtl/pipe_skid_stage_reg_if.sv
// pipe_skid_stage_reg_if
//   Handshake bundle between fetch, the IF/ID skid stage and decode.
//   master : driven by the environment (fetch offer, flush, decode ready)
//   slave  : the skid stage itself
//   Signals:
//     in_valid/in_ready/in_pc/in_instr  - fetch offer and acceptance
//     flush                             - squash all held entries
//     out_valid/out_ready/out_pc/out_instr - head entry towards decode
//     occupancy                         - valid entries held (0..2)
//     flush_count                       - saturating count of squashed entries
interface pipe_skid_stage_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CNT_W  = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_instr;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, occupancy, flush_count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, occupancy, flush_count
  );
endinterface

// File: rtl/pipe_skid_stage_reg.sv
// pipe_skid_stage_reg
//   Two-entry IF/ID skid buffer. Head register M drives decode, skid
//   register S catches the one instruction that arrives while decode is
//   stalling. Flush empties both and counts discarded valid entries.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high
//     bus   - pipe_skid_stage_reg_if.slave handshake bundle
//   All outputs come from registers or state decode; no in_* -> out_* path.
module pipe_skid_stage_reg #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       PC_W      = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_skid_stage_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   m_pc_q, m_pc_d;
  logic [DATA_W-1:0] m_instr_q, m_instr_d;
  logic [PC_W-1:0]   s_pc_q, s_pc_d;
  logic [DATA_W-1:0] s_instr_q, s_instr_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic              accept;
  logic              pop;
  logic [1:0]        occ;
  logic [1:0]        squashed;
  logic [CNT_W+1:0]  cnt_sum;

  always_comb begin
    case (state_q)
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  assign accept = bus.in_valid & (state_q != FULL);
  assign pop    = (state_q != EMPTY) & bus.out_ready;

  // An entry popped in the flush cycle reaches decode, so it is not squashed.
  assign squashed = occ - {1'b0, pop};
  // Two guard bits so the saturation test sees any overflow, even for tiny CNT_W.
  assign cnt_sum  = {2'b00, flush_count_q} + {{CNT_W{1'b0}}, squashed};

  always_comb begin
    state_d       = state_q;
    m_pc_d        = m_pc_q;
    m_instr_d     = m_instr_q;
    s_pc_d        = s_pc_q;
    s_instr_d     = s_instr_q;
    flush_count_d = flush_count_q;

    if (bus.flush) begin
      state_d   = EMPTY;
      m_pc_d    = '0;
      m_instr_d = NOP_INSTR;
      s_pc_d    = '0;
      s_instr_d = NOP_INSTR;
      if (cnt_sum[CNT_W+1:CNT_W] != 2'b00) flush_count_d = '1;
      else                                 flush_count_d = cnt_sum[CNT_W-1:0];
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_pc_d    = bus.in_pc;
            m_instr_d = bus.in_instr;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            m_pc_d    = bus.in_pc;
            m_instr_d = bus.in_instr;
          end else if (accept) begin
            s_pc_d    = bus.in_pc;
            s_instr_d = bus.in_instr;
            state_d   = FULL;
          end else if (pop) begin
            m_pc_d    = '0;
            m_instr_d = NOP_INSTR;
            state_d   = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            m_pc_d    = s_pc_q;
            m_instr_d = s_instr_q;
            s_pc_d    = '0;
            s_instr_d = NOP_INSTR;
            state_d   = ONE;
          end
        end
        default: begin
          state_d   = EMPTY;
          m_pc_d    = '0;
          m_instr_d = NOP_INSTR;
          s_pc_d    = '0;
          s_instr_d = NOP_INSTR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= EMPTY;
      m_pc_q        <= '0;
      m_instr_q     <= NOP_INSTR;
      s_pc_q        <= '0;
      s_instr_q     <= NOP_INSTR;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      m_pc_q        <= m_pc_d;
      m_instr_q     <= m_instr_d;
      s_pc_q        <= s_pc_d;
      s_instr_q     <= s_instr_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.in_ready    = (state_q != FULL);
  assign bus.out_valid   = (state_q != EMPTY);
  assign bus.out_pc      = m_pc_q;
  assign bus.out_instr   = m_instr_q;
  assign bus.occupancy   = occ;
  assign bus.flush_count = flush_count_q;

endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
module tb_pipe_skid_stage_reg;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int unsigned exp_cnt;

  pipe_skid_stage_reg_if #(.DATA_W(32), .PC_W(32), .CNT_W(16)) b1 ();
  pipe_skid_stage_reg_if #(.DATA_W(32), .PC_W(32), .CNT_W(2))  b2 ();

  pipe_skid_stage_reg #(.DATA_W(32), .PC_W(32), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  pipe_skid_stage_reg #(.DATA_W(32), .PC_W(32), .NOP_INSTR(NOP), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer1(input logic v, input logic [31:0] pc);
    b1.in_valid = v;
    b1.in_pc    = pc;
    b1.in_instr = instr_of(pc);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if ({b1.out_valid, b1.in_ready, b1.occupancy} !== 4'b0100) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", {b1.out_valid, b1.in_ready, b1.occupancy}, 4'b0100); end
    checks++; if (b1.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", b1.out_pc, 32'h0); end
    checks++; if (b1.out_instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", b1.out_instr, NOP); end
    checks++; if (b1.flush_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", b1.flush_count); end
    step();
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3] = '{32'h00, 32'h04, 32'h08};
    b1.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer1(1'b1, pcs[i]);
      step();
      checks++; if ({b1.out_valid, b1.in_ready, b1.occupancy} !== 4'b1101) begin errors++; $display("FAIL stream_ctl%0d got=%b exp=%b", i, {b1.out_valid, b1.in_ready, b1.occupancy}, 4'b1101); end
      checks++; if (b1.out_pc !== pcs[i] || b1.out_instr !== instr_of(pcs[i])) begin errors++; $display("FAIL stream_data%0d got=%h/%h exp=%h/%h", i, b1.out_pc, b1.out_instr, pcs[i], instr_of(pcs[i])); end
    end
    offer1(1'b0, 32'h0);
    step();
    checks++; if ({b1.out_valid, b1.occupancy, b1.out_pc, b1.out_instr} !== {1'b0, 2'd0, 32'h0, NOP}) begin errors++; $display("FAIL stream_drain got=%b/%0d/%h/%h exp=0/0/0/%h", b1.out_valid, b1.occupancy, b1.out_pc, b1.out_instr, NOP); end
  endtask

  task automatic test_skid();
    b1.out_ready = 1'b1;
    offer1(1'b1, 32'h10);
    step();
    b1.out_ready = 1'b0;
    offer1(1'b1, 32'h14);
    step();
    checks++; if ({b1.in_ready, b1.occupancy, b1.out_pc} !== {1'b0, 2'd2, 32'h10}) begin errors++; $display("FAIL skid_full got=%b/%0d/%h exp=0/2/10", b1.in_ready, b1.occupancy, b1.out_pc); end
    offer1(1'b1, 32'h18);
    step();
    checks++; if ({b1.in_ready, b1.occupancy, b1.out_pc} !== {1'b0, 2'd2, 32'h10}) begin errors++; $display("FAIL skid_hold got=%b/%0d/%h exp=0/2/10", b1.in_ready, b1.occupancy, b1.out_pc); end
    b1.out_ready = 1'b1;
    step();
    checks++; if ({b1.in_ready, b1.occupancy, b1.out_pc} !== {1'b1, 2'd1, 32'h14} || b1.out_instr !== instr_of(32'h14)) begin errors++; $display("FAIL skid_pop1 got=%b/%0d/%h exp=1/1/14", b1.in_ready, b1.occupancy, b1.out_pc); end
    step();
    checks++; if ({b1.occupancy, b1.out_pc} !== {2'd1, 32'h18} || b1.out_instr !== instr_of(32'h18)) begin errors++; $display("FAIL skid_pop2 got=%0d/%h exp=1/18", b1.occupancy, b1.out_pc); end
    offer1(1'b0, 32'h0);
    step();
    checks++; if ({b1.out_valid, b1.occupancy} !== 3'b000) begin errors++; $display("FAIL skid_empty got=%b/%0d exp=0/0", b1.out_valid, b1.occupancy); end
  endtask

  task automatic test_flush_full();
    b1.out_ready = 1'b0;
    offer1(1'b1, 32'h30);
    step();
    offer1(1'b1, 32'h34);
    step();
    checks++; if (b1.occupancy !== 2'd2) begin errors++; $display("FAIL fflush_fill got=%0d exp=2", b1.occupancy); end
    b1.flush = 1'b1;
    offer1(1'b1, 32'h20);
    step();
    b1.flush = 1'b0;
    offer1(1'b0, 32'h0);
    exp_cnt += 2;
    checks++; if ({b1.out_valid, b1.occupancy, b1.out_pc, b1.out_instr} !== {1'b0, 2'd0, 32'h0, NOP}) begin errors++; $display("FAIL fflush_out got=%b/%0d/%h/%h exp=0/0/0/%h", b1.out_valid, b1.occupancy, b1.out_pc, b1.out_instr, NOP); end
    checks++; if (b1.flush_count !== 16'(exp_cnt)) begin errors++; $display("FAIL fflush_cnt got=%0d exp=%0d", b1.flush_count, exp_cnt); end
    step();
    checks++; if ({b1.out_valid, b1.occupancy} !== 3'b000) begin errors++; $display("FAIL fflush_discard got=%b/%0d exp=0/0", b1.out_valid, b1.occupancy); end
  endtask

  task automatic test_flush_pop();
    // Flush in ONE with decode popping: nothing squashed.
    b1.out_ready = 1'b0;
    offer1(1'b1, 32'h40);
    step();
    offer1(1'b0, 32'h0);
    b1.flush = 1'b1;
    b1.out_ready = 1'b1;
    checks++; if ({b1.out_valid, b1.out_pc} !== {1'b1, 32'h40}) begin errors++; $display("FAIL pflush_seen got=%b/%h exp=1/40", b1.out_valid, b1.out_pc); end
    step();
    b1.flush = 1'b0;
    b1.out_ready = 1'b0;
    checks++; if ({b1.occupancy, b1.flush_count} !== {2'd0, 16'(exp_cnt)}) begin errors++; $display("FAIL pflush_one got=%0d/%0d exp=0/%0d", b1.occupancy, b1.flush_count, exp_cnt); end
    // Flush in FULL with a pop: only the skid entry is squashed.
    offer1(1'b1, 32'h50);
    step();
    offer1(1'b1, 32'h54);
    step();
    offer1(1'b0, 32'h0);
    b1.flush = 1'b1;
    b1.out_ready = 1'b1;
    step();
    b1.flush = 1'b0;
    b1.out_ready = 1'b0;
    exp_cnt += 1;
    checks++; if ({b1.occupancy, b1.flush_count} !== {2'd0, 16'(exp_cnt)}) begin errors++; $display("FAIL pflush_full got=%0d/%0d exp=0/%0d", b1.occupancy, b1.flush_count, exp_cnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
    b2.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b2.in_valid = 1'b1;
      b2.in_pc    = 32'h100 + 32'(k * 8);
      b2.in_instr = instr_of(b2.in_pc);
      step();
      b2.in_pc    = 32'h104 + 32'(k * 8);
      b2.in_instr = instr_of(b2.in_pc);
      step();
      b2.in_valid = 1'b0;
      b2.flush    = 1'b1;
      step();
      b2.flush    = 1'b0;
      checks++; if (b2.flush_count !== exp_sat[k]) begin errors++; $display("FAIL sat%0d got=%0d exp=%0d", k, b2.flush_count, exp_sat[k]); end
    end
  endtask

  task automatic test_async_reset();
    b1.out_ready = 1'b0;
    offer1(1'b1, 32'h60);
    step();
    offer1(1'b1, 32'h64);
    step();
    offer1(1'b0, 32'h0);
    checks++; if (b1.occupancy !== 2'd2) begin errors++; $display("FAIL areset_fill got=%0d exp=2", b1.occupancy); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({b1.out_valid, b1.in_ready, b1.occupancy} !== 4'b0100) begin errors++; $display("FAIL areset_ctl got=%b exp=%b", {b1.out_valid, b1.in_ready, b1.occupancy}, 4'b0100); end
    checks++; if ({b1.out_pc, b1.out_instr, b1.flush_count} !== {32'h0, NOP, 16'd0}) begin errors++; $display("FAIL areset_data got=%h/%h/%0d exp=0/%h/0", b1.out_pc, b1.out_instr, b1.flush_count, NOP); end
    step();
    reset = 1'b0;
    offer1(1'b1, 32'h70);
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL areset_early got=%b exp=0", b1.out_valid); end
    step();
    offer1(1'b0, 32'h0);
    checks++; if ({b1.out_valid, b1.occupancy, b1.out_pc} !== {1'b1, 2'd1, 32'h70} || b1.out_instr !== instr_of(32'h70)) begin errors++; $display("FAIL areset_first got=%b/%0d/%h exp=1/1/70", b1.out_valid, b1.occupancy, b1.out_pc); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_cnt = 0;
    offer1(1'b0, 32'h0);
    b1.flush = 1'b0;
    b1.out_ready = 1'b0;
    b2.in_valid = 1'b0;
    b2.in_pc = '0;
    b2.in_instr = '0;
    b2.flush = 1'b0;
    b2.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush_full();
    test_flush_pop();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage_reg.md
# pipe_skid_stage_reg

Parametrised IF/ID pipeline register for the ARM-with-SRAM core. It replaces the single-entry register with a two-entry skid buffer under valid/ready handshakes. Instructions fetched while the downstream stage is stalled are therefore kept rather than refetched. It also supports flush with NOP-bubble insertion and a saturating count of squashed instructions for performance monitoring.

## Interface
- DATA_W, 32, instruction width
- PC_W, 32, PC width
- NOP_INSTR, {DATA_W{1'b0}}, value driven on out_instr when empty or flushed
- CNT_W, 16, flush_count width
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch offers in_pc/in_instr (SRAM data ready)
- in_ready  output  1  stage can accept this cycle
- in_pc  input  PC_W  PC of offered instruction
- in_instr  input  DATA_W  offered instruction
- flush  input  1  squash all held entries (branch taken)
- out_valid  output  1  out_pc/out_instr hold a valid instruction
- out_ready  input  1  decode consumes this cycle (deasserted = freeze)
- out_pc  output  PC_W  PC of head entry
- out_instr  output  DATA_W  head instruction
- occupancy  output  2  number of valid entries (0..2)
- flush_count  output  CNT_W  saturating count of squashed valid entries

## Operation
- Storage: head register M (drives the outputs) and skid register S. All outputs come directly from registers or state decode; there is no combinational path from in_* to out_*.
- accept = in_valid & in_ready; pop = out_valid & out_ready.
- States: EMPTY (occupancy 0), ONE (M valid), FULL (M and S valid).
- in_ready = (state != FULL); out_valid = (state != EMPTY).
- EMPTY: on accept, M<=in and go to ONE. A pop is impossible in this state.
- ONE:
  - accept & pop: M<=in, stay in ONE.
  - accept & !pop: S<=in, go to FULL.
  - pop & !accept: go to EMPTY, M<=(0, NOP_INSTR).
  - neither: hold.
- FULL: no accept is possible. On pop, M<=S, S<=(0, NOP_INSTR), go to ONE. Otherwise hold.
- flush, priority below reset and above everything else:
  - state<=EMPTY; M and S are set to (0, NOP_INSTR).
  - The in_* offer in the same cycle is discarded, even though in_ready may be 1.
  - A pop in the same cycle is still seen by decode; the popped entry is not counted as squashed.
- flush_count on flush: adds the number of valid entries discarded. That is occupancy, minus 1 if a pop occurs in the same cycle. Saturates at all-ones with no wrap.
- When EMPTY, out_pc=0 and out_instr=NOP_INSTR, so decode sees a bubble.
- Reset: state EMPTY; M and S = (0, NOP_INSTR); flush_count=0.

## Timing
- Reset values: out_valid=0, in_ready=1, out_pc=0, out_instr=NOP_INSTR, occupancy=0, flush_count=0. These take effect immediately on reset assertion, without waiting for a clock edge.
- Reset asserted mid-operation discards all entries and the count immediately. The first accept occurs on the first rising edge with reset low.
- Latency: accept at edge N gives out_valid=1 with that data after edge N.
- Throughput: 1 instruction/cycle while out_ready=1.
- Stall: after out_ready falls, at most one further instruction is accepted (into S). in_ready falls one cycle after the stall begins.
- Drain: in_ready rises the cycle after the first pop from FULL. No entry is lost or duplicated.
- Order is strictly FIFO: M is always older than S.

## Test plan
- Stream: out_ready=1; accept PCs 0x00, 0x04, 0x08 on consecutive edges -> out_pc 0x00, 0x04, 0x08 one cycle later each; occupancy stays 1; in_ready stays 1.
- Skid: accept 0x10, then drop out_ready and offer 0x14, 0x18 -> FULL holding 0x10/0x14; in_ready=0; 0x18 is held upstream. Raise out_ready -> 0x10, 0x14, 0x18 emitted in order, no loss.
- Flush when FULL with out_ready=0 -> next cycle occupancy=0, out_instr=NOP_INSTR, flush_count +=2. The same-cycle in_valid offer of 0x20 does not appear on the outputs.
- Flush with pop in ONE -> the popped entry is consumed, flush_count +0. Flush with pop in FULL -> flush_count +1.
- Saturation: CNT_W=2; four flushes when FULL -> flush_count reads 2, then 3, then stays 3.
- Async reset asserted between edges while FULL -> outputs show the reset values immediately. After release, the first accept appears one edge later.
